// File: rtl/axil_to_wbm.sv
// AXI4-Lite slave to pipelined Wishbone master bridge: one transaction in flight,
// round-robin between reads and writes, SLVERR on WB error or ack timeout.
module axil_to_wbm #(
   parameter int C_AXI_ADDR_WIDTH = 28,
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT          = 255
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_axi_awvalid,
   output logic                          o_axi_awready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
   input  logic                          i_axi_wvalid,
   output logic                          o_axi_wready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
   output logic                          o_axi_bvalid,
   input  logic                          i_axi_bready,
   output logic [1:0]                    o_axi_bresp,
   input  logic                          i_axi_arvalid,
   output logic                          o_axi_arready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
   output logic                          o_axi_rvalid,
   input  logic                          i_axi_rready,
   output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata,
   output logic [1:0]                    o_axi_rresp,
   output logic                          o_wb_cyc,
   output logic                          o_wb_stb,
   output logic                          o_wb_we,
   output logic [C_AXI_ADDR_WIDTH-3:0]   o_wb_addr,
   output logic [C_AXI_DATA_WIDTH-1:0]   o_wb_data,
   output logic [C_AXI_DATA_WIDTH/8-1:0] o_wb_sel,
   input  logic                          i_wb_ack,
   input  logic                          i_wb_stall,
   input  logic [C_AXI_DATA_WIDTH-1:0]   i_wb_data,
   input  logic                          i_wb_err
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_WBUS, S_BRESP, S_RRESP} state_t;

   state_t          r_state;
   logic            r_last_wr;
   logic [CW-1:0]   r_cnt;

   logic w_idle, w_wr_req, w_rd_req, w_take_wr, w_take_rd, w_tmo, w_ok, w_done;
   logic w_unused_addr_lsb;

   assign w_unused_addr_lsb = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};

   // Readies are granted only from IDLE; on a tie the kind not served last wins.
   assign w_idle    = (r_state == S_IDLE) && !i_reset;
   assign w_wr_req  = i_axi_awvalid && i_axi_wvalid;
   assign w_rd_req  = i_axi_arvalid;
   assign w_take_wr = w_idle && w_wr_req && (!w_rd_req || !r_last_wr);
   assign w_take_rd = w_idle && w_rd_req && !w_take_wr;

   assign o_axi_awready = w_take_wr;
   assign o_axi_wready  = w_take_wr;
   assign o_axi_arready = w_take_rd;

   // r_cnt holds the number of cyc cycles already elapsed, so cyc stays up TIMEOUT cycles.
   assign w_tmo  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
   assign w_ok   = i_wb_ack && !i_wb_err;
   assign w_done = i_wb_ack || i_wb_err || w_tmo;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_last_wr    <= 1'b0;
         r_cnt        <= '0;
         o_wb_cyc     <= 1'b0;
         o_wb_stb     <= 1'b0;
         o_wb_we      <= 1'b0;
         o_wb_addr    <= '0;
         o_wb_data    <= '0;
         o_wb_sel     <= '0;
         o_axi_bvalid <= 1'b0;
         o_axi_bresp  <= RESP_OKAY;
         o_axi_rvalid <= 1'b0;
         o_axi_rresp  <= RESP_OKAY;
         o_axi_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_take_wr) begin
                  r_state   <= S_WBUS;
                  r_last_wr <= 1'b1;
                  r_cnt     <= '0;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b1;
                  o_wb_addr <= i_axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
                  o_wb_data <= i_axi_wdata;
                  o_wb_sel  <= i_axi_wstrb;
               end else if (w_take_rd) begin
                  r_state   <= S_WBUS;
                  r_last_wr <= 1'b0;
                  r_cnt     <= '0;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b0;
                  o_wb_addr <= i_axi_araddr[C_AXI_ADDR_WIDTH-1:2];
                  o_wb_data <= '0;
                  o_wb_sel  <= '1;
               end
            end
            S_WBUS: begin
               if (o_wb_stb && !i_wb_stall)
                  o_wb_stb <= 1'b0;
               if (w_done) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  if (o_wb_we) begin
                     r_state      <= S_BRESP;
                     o_axi_bvalid <= 1'b1;
                     o_axi_bresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
                  end else begin
                     r_state      <= S_RRESP;
                     o_axi_rvalid <= 1'b1;
                     o_axi_rresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
                     o_axi_rdata  <= w_ok ? i_wb_data : '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BRESP: begin
               if (i_axi_bready) begin
                  o_axi_bvalid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            S_RRESP: begin
               if (i_axi_rready) begin
                  o_axi_rvalid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axil_to_wbm.sv
// Bench for axil_to_wbm: scripted scenarios plus randomized transactions against a WB slave model.
module tb_axil_to_wbm;
   localparam int AAW = 28;
   localparam int TMO = 255;

   logic clk, rst;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [AAW-1:0] awaddr, araddr;
   logic [31:0] wdata, rdata, wb_dat_o, wb_dat_i;
   logic [3:0] wstrb, wb_sel;
   logic [1:0] bresp, rresp;
   logic wb_cyc, wb_stb, wb_we, wb_ack, wb_stall, wb_err;
   logic [AAW-3:0] wb_addr;

   int checks = 0, passed = 0, cycle = 0;
   int cyc_rises = 0, cyc_hi = 0, stb_hi = 0;
   int sl_mode = 0, sl_stall = 0;   // mode: 0 ack, 1 err, 2 silent, 3 ack+err
   logic [31:0] sl_data = 32'h0;
   logic [AAW-3:0] q_addr[$];
   logic q_we[$];
   logic [3:0] q_sel[$];
   logic [31:0] q_dat[$];

   axil_to_wbm #(.C_AXI_ADDR_WIDTH(AAW), .C_AXI_DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_axi_awvalid(awvalid), .o_axi_awready(awready), .i_axi_awaddr(awaddr),
      .i_axi_wvalid(wvalid), .o_axi_wready(wready), .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
      .o_axi_bvalid(bvalid), .i_axi_bready(bready), .o_axi_bresp(bresp),
      .i_axi_arvalid(arvalid), .o_axi_arready(arready), .i_axi_araddr(araddr),
      .o_axi_rvalid(rvalid), .i_axi_rready(rready), .o_axi_rdata(rdata), .o_axi_rresp(rresp),
      .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
      .o_wb_data(wb_dat_o), .o_wb_sel(wb_sel),
      .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_dat_i), .i_wb_err(wb_err)
   );

   initial begin clk = 1'b0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cycle++; end
   initial begin #500000; $display("FAIL watchdog expired at cycle %0d", cycle); $fatal(1); end

   // Wishbone slave model: stalls sl_stall cycles, then answers one cycle after the beat.
   initial begin
      logic prev_cyc, ack_pending;
      int stall_left;
      prev_cyc = 1'b0; ack_pending = 1'b0; stall_left = 0;
      wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = 32'h0;
      forever begin
         @(negedge clk);
         wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = $urandom;
         if (rst) begin
            ack_pending = 1'b0; prev_cyc = 1'b0;
         end else begin
            if (ack_pending) begin
               ack_pending = 1'b0;
               if (sl_mode == 0 || sl_mode == 3) begin wb_ack = 1'b1; wb_dat_i = sl_data; end
               if (sl_mode == 1 || sl_mode == 3) wb_err = 1'b1;
            end
            if (wb_cyc) cyc_hi++;
            if (wb_cyc && !prev_cyc) begin cyc_rises++; stall_left = sl_stall; end
            prev_cyc = wb_cyc;
            if (wb_cyc && wb_stb) begin
               stb_hi++;
               if (stall_left > 0) begin
                  wb_stall = 1'b1; stall_left--;
               end else begin
                  q_addr.push_back(wb_addr); q_we.push_back(wb_we);
                  q_sel.push_back(wb_sel); q_dat.push_back(wb_dat_o);
                  ack_pending = (sl_mode != 2);
               end
            end
         end
      end
   end

   task automatic clear_q();
      q_addr.delete(); q_we.delete(); q_sel.delete(); q_dat.delete();
   endtask

   // One AXI transaction; lat = cycles from accept to response valid.
   task automatic axi_txn(input bit wr, input logic [AAW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold, output logic [1:0] resp,
                          output logic [31:0] rd, output int lat, output bit ok);
      int acc, n;
      ok = 1'b0; resp = 2'bxx; rd = 'x; lat = -1;
      @(negedge clk);
      if (wr) begin awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s; end
      else begin arvalid = 1'b1; araddr = a; end
      #1;
      n = 0;
      while (!(wr ? (awready && wready) : arready) && n < 100) begin @(negedge clk); #1; n++; end
      if (n >= 100) begin awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; return; end
      acc = cycle;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      n = 0;
      while (!(wr ? bvalid : rvalid) && n < 600) begin @(negedge clk); n++; end
      if (n >= 600) return;
      lat = cycle - acc;
      resp = wr ? bresp : rresp;
      rd = rdata;
      repeat (hold) @(negedge clk);
      if (wr) bready = 1'b1; else rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      ok = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({awready, wready, arready} !== 3'b000) $display("FAIL reset_readies got %b exp 000", {awready, wready, arready});
      else passed++;
      checks++;
      if ({bvalid, bresp, rvalid, rresp, rdata, wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_o, wb_sel} !== '0)
         $display("FAIL reset_outputs got %h exp 0",
                  {bvalid, bresp, rvalid, rresp, rdata, wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_o, wb_sel});
      else passed++;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write_basic();
      logic [1:0] resp; logic [31:0] rd; int lat, r0, s0; bit ok;
      sl_mode = 0; sl_stall = 0; clear_q(); r0 = cyc_rises; s0 = stb_hi;
      axi_txn(1'b1, 28'h100, 32'hDEADBEEF, 4'b0011, 0, resp, rd, lat, ok);
      checks++; if (!ok) $display("FAIL wr_done got 0 exp 1"); else passed++;
      checks++;
      if ({q_addr.size(), stb_hi - s0, cyc_rises - r0} !== {32'd1, 32'd1, 32'd1})
         $display("FAIL wr_beats got beats=%0d stb=%0d cyc=%0d exp 1 1 1", q_addr.size(), stb_hi - s0, cyc_rises - r0);
      else passed++;
      checks++;
      if ({q_we[0], q_addr[0], q_sel[0], q_dat[0]} !== {1'b1, 26'h40, 4'h3, 32'hDEADBEEF})
         $display("FAIL wr_beat got we=%b a=%h sel=%h d=%h exp 1 40 3 deadbeef", q_we[0], q_addr[0], q_sel[0], q_dat[0]);
      else passed++;
      checks++; if (lat !== 3) $display("FAIL wr_latency got %0d exp 3", lat); else passed++;
      checks++; if (resp !== 2'b00) $display("FAIL wr_bresp got %b exp 00", resp); else passed++;
   endtask

   task automatic test_read_stall();
      logic [1:0] resp; logic [31:0] rd; int lat, s0; bit ok;
      sl_mode = 0; sl_stall = 2; sl_data = 32'h12345678; clear_q(); s0 = stb_hi;
      axi_txn(1'b0, 28'h204, 32'h0, 4'h0, 0, resp, rd, lat, ok);
      checks++; if (!ok) $display("FAIL rd_done got 0 exp 1"); else passed++;
      checks++; if (stb_hi - s0 !== 3) $display("FAIL rd_stb_cycles got %0d exp 3", stb_hi - s0); else passed++;
      checks++;
      if ({q_we[0], q_addr[0], q_sel[0], q_dat[0]} !== {1'b0, 26'h81, 4'hf, 32'h0})
         $display("FAIL rd_beat got we=%b a=%h sel=%h d=%h exp 0 81 f 0", q_we[0], q_addr[0], q_sel[0], q_dat[0]);
      else passed++;
      checks++;
      if ({rd, resp} !== {32'h12345678, 2'b00}) $display("FAIL rd_data got %h/%b exp 12345678/00", rd, resp);
      else passed++;
      checks++; if (lat !== 5) $display("FAIL rd_latency got %0d exp 5", lat); else passed++;
      sl_stall = 0;
   endtask

   task automatic test_arbitration();
      int n, r0;
      logic [AAW-1:0] wa, ra;
      logic [31:0] wd;
      wa = AAW'($urandom); ra = AAW'($urandom); wd = $urandom;
      sl_mode = 0; sl_stall = 0; sl_data = $urandom | 32'h1; clear_q(); r0 = cyc_rises;
      @(negedge clk);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; awaddr = wa; araddr = ra; wdata = wd; wstrb = 4'hc;
      #1;
      checks++;
      if ({awready, wready, arready} !== 3'b110) $display("FAIL arb_first got %b exp 110", {awready, wready, arready});
      else passed++;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      #1;
      n = 0;
      while (!arready && n < 50) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      arvalid = 1'b0;
      while (!rvalid && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      checks++; if (n >= 100) $display("FAIL arb_done got n=%0d exp <100", n); else passed++;
      checks++;
      if ({cyc_rises - r0, q_addr.size()} !== {32'd2, 32'd2})
         $display("FAIL arb_count got cyc=%0d beats=%0d exp 2 2", cyc_rises - r0, q_addr.size());
      else passed++;
      checks++;
      if ({q_we[0], q_addr[0], q_sel[0], q_dat[0], q_we[1], q_addr[1], q_sel[1]} !==
          {1'b1, wa[AAW-1:2], 4'hc, wd, 1'b0, ra[AAW-1:2], 4'hf})
         $display("FAIL arb_order got %b %h %b %h exp 1 %h 0 %h", q_we[0], q_addr[0], q_we[1], q_addr[1],
                  wa[AAW-1:2], ra[AAW-1:2]);
      else passed++;
   endtask

   task automatic test_timeout();
      logic [1:0] resp; logic [31:0] rd; int lat, h0; bit ok;
      sl_mode = 2; h0 = cyc_hi;
      axi_txn(1'b0, AAW'($urandom), 32'h0, 4'h0, 0, resp, rd, lat, ok);
      checks++; if (!ok) $display("FAIL tmo_done got 0 exp 1"); else passed++;
      checks++; if (cyc_hi - h0 !== TMO) $display("FAIL tmo_cyc_cycles got %0d exp %0d", cyc_hi - h0, TMO); else passed++;
      checks++; if ({rd, resp} !== {32'h0, 2'b10}) $display("FAIL tmo_resp got %h/%b exp 0/10", rd, resp); else passed++;
      checks++; if (lat !== TMO + 1) $display("FAIL tmo_latency got %0d exp %0d", lat, TMO + 1); else passed++;
   endtask

   task automatic test_ack_err();
      logic [1:0] resp; logic [31:0] rd; int lat; bit ok;
      sl_mode = 3; sl_data = $urandom | 32'h1;
      axi_txn(1'b0, AAW'($urandom), 32'h0, 4'h0, 1, resp, rd, lat, ok);
      checks++;
      if ({ok, rd, resp} !== {1'b1, 32'h0, 2'b10}) $display("FAIL ackerr_rd got %b/%h/%b exp 1/0/10", ok, rd, resp);
      else passed++;
      axi_txn(1'b1, AAW'($urandom), $urandom, 4'hf, 0, resp, rd, lat, ok);
      checks++;
      if ({ok, resp} !== {1'b1, 2'b10}) $display("FAIL ackerr_wr got %b/%b exp 1/10", ok, resp);
      else passed++;
   endtask

   task automatic test_bready_hold();
      int n, r0;
      sl_mode = 1; sl_stall = 0;
      @(negedge clk);
      awvalid = 1'b1; wvalid = 1'b1; awaddr = AAW'($urandom); wdata = $urandom; wstrb = 4'hf;
      #1;
      checks++; if ({awready, wready} !== 2'b11) $display("FAIL bhold_accept got %b exp 11", {awready, wready}); else passed++;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      r0 = cyc_rises;
      for (int i = 0; i < 10; i++) begin
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
         #1;
         checks++;
         if ({bvalid, bresp, awready, wready, arready} !== 6'b110000)
            $display("FAIL bhold_%0d got %b exp 110000", i, {bvalid, bresp, awready, wready, arready});
         else passed++;
         @(negedge clk);
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      #1;
      checks++;
      if ({bvalid, cyc_rises - r0} !== {1'b0, 32'd0}) $display("FAIL bhold_release got bvalid=%b cyc=%0d exp 0 0", bvalid, cyc_rises - r0);
      else passed++;
   endtask

   task automatic test_reset_mid();
      bit bad;
      sl_mode = 2;
      @(negedge clk);
      arvalid = 1'b1; araddr = AAW'($urandom);
      @(negedge clk);
      arvalid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (wb_cyc !== 1'b1) $display("FAIL rstmid_pre got cyc=%b exp 1", wb_cyc); else passed++;
      #1 rst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      #1;
      checks++;
      if ({awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata, wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_o, wb_sel} !== '0)
         $display("FAIL rstmid_outputs got %h exp 0",
                  {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata, wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_o, wb_sel});
      else passed++;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bvalid || rvalid || wb_cyc) bad = 1'b1;
      end
      checks++; if (bad) $display("FAIL rstmid_quiet got activity exp none"); else passed++;
   endtask

   task automatic test_random();
      logic [1:0] resp, exp_resp; logic [31:0] rd, exp_rd, d; logic [AAW-1:0] a; logic [3:0] s;
      int lat, r0, hold, m; bit ok, wr;
      for (int i = 0; i < 24; i++) begin
         wr = 1'($urandom); a = AAW'($urandom); d = $urandom; s = 4'($urandom);
         m = $urandom_range(0, 2); if (m == 2) m = 3;
         sl_mode = m; sl_stall = $urandom_range(0, 3); sl_data = $urandom; hold = $urandom_range(0, 3);
         exp_resp = (m == 0) ? 2'b00 : 2'b10;
         exp_rd = (m == 0) ? sl_data : 32'h0;
         clear_q(); r0 = cyc_rises;
         axi_txn(wr, a, d, s, hold, resp, rd, lat, ok);
         checks++;
         if ({ok, q_addr.size(), cyc_rises - r0} !== {1'b1, 32'd1, 32'd1})
            $display("FAIL rnd%0d_done got ok=%b beats=%0d cyc=%0d exp 1 1 1", i, ok, q_addr.size(), cyc_rises - r0);
         else passed++;
         checks++;
         if ({q_we[0], q_addr[0], q_sel[0], q_dat[0]} !== {wr, a[AAW-1:2], (wr ? s : 4'hf), (wr ? d : 32'h0)})
            $display("FAIL rnd%0d_beat got %b %h %h %h exp %b %h %h %h", i, q_we[0], q_addr[0], q_sel[0], q_dat[0],
                     wr, a[AAW-1:2], (wr ? s : 4'hf), (wr ? d : 32'h0));
         else passed++;
         checks++; if (resp !== exp_resp) $display("FAIL rnd%0d_resp got %b exp %b", i, resp, exp_resp); else passed++;
         checks++; if (lat !== 3 + sl_stall) $display("FAIL rnd%0d_lat got %0d exp %0d", i, lat, 3 + sl_stall); else passed++;
         if (!wr) begin
            checks++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata got %h exp %h", i, rd, exp_rd); else passed++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      test_reset();
      test_write_basic();
      test_read_stall();
      test_arbitration();
      test_timeout();
      test_ack_err();
      test_bready_hold();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
